// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA rectangle-fill engine.
// Coordinate widths follow the framebuffer address layout {y[6:0], x[7:0]}.
package vga_pkg;

    localparam int H_RES_DEF = 160;
    localparam int V_RES_DEF = 120;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 12;
    localparam int A_W = X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FINISH
    } state_e;

endpackage

// File: rtl/vga_rect_fill_if.sv
// Bundle of the fill request, MCU write port and framebuffer write bus.
// The master side requests fills and issues MCU writes; the slave side is the engine.
interface vga_rect_fill_if;

    logic                    start;
    logic [vga_pkg::X_W-1:0] x0;
    logic [vga_pkg::X_W-1:0] x1;
    logic [vga_pkg::Y_W-1:0] y0;
    logic [vga_pkg::Y_W-1:0] y1;
    logic [vga_pkg::C_W-1:0] color;
    logic [vga_pkg::A_W-1:0] cpu_wa;
    logic [vga_pkg::C_W-1:0] cpu_wd;
    logic                    cpu_we;
    logic [vga_pkg::A_W-1:0] wa;
    logic [vga_pkg::C_W-1:0] wd;
    logic                    we;
    logic                    busy;
    logic                    done;

    modport master (
        output start, x0, x1, y0, y1, color, cpu_wa, cpu_wd, cpu_we,
        input  wa, wd, we, busy, done
    );

    modport slave (
        input  start, x0, x1, y0, y1, color, cpu_wa, cpu_wd, cpu_we,
        output wa, wd, we, busy, done
    );

endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: writes one pixel per cycle in row-major order into the
// framebuffer write port, yielding the port to MCU writes whenever CPU_WE is high.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic           CLK_50MHz,
    input  logic           RST_N,
    input  logic           START,
    input  logic [X_W-1:0] X0,
    input  logic [X_W-1:0] X1,
    input  logic [Y_W-1:0] Y0,
    input  logic [Y_W-1:0] Y1,
    input  logic [C_W-1:0] COLOR,
    input  logic [A_W-1:0] CPU_WA,
    input  logic [C_W-1:0] CPU_WD,
    input  logic           CPU_WE,
    output logic [A_W-1:0] WA,
    output logic [C_W-1:0] WD,
    output logic           WE,
    output logic           BUSY,
    output logic           DONE
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    state_e         state_q;
    logic [X_W-1:0] xmin_q, xmax_q, x_q;
    logic [Y_W-1:0] ymax_q, y_q;
    logic [C_W-1:0] color_q;
    logic           last_q;
    logic [A_W-1:0] wa_q;
    logic [C_W-1:0] wd_q;
    logic           we_q, busy_q, done_q;

    // Normalised and clipped corners of the incoming request.
    logic [X_W-1:0] nx_min, nx_hi, nx_max;
    logic [Y_W-1:0] ny_min, ny_hi, ny_max;
    logic           skip;

    always_comb begin
        nx_min = (X0 < X1) ? X0 : X1;
        nx_hi  = (X0 < X1) ? X1 : X0;
        ny_min = (Y0 < Y1) ? Y0 : Y1;
        ny_hi  = (Y0 < Y1) ? Y1 : Y0;
        nx_max = (nx_hi > X_LAST) ? X_LAST : nx_hi;
        ny_max = (ny_hi > Y_LAST) ? Y_LAST : ny_hi;
        skip   = (nx_min > X_LAST) || (ny_min > Y_LAST);
    end

    // On the accepting edge the first pixel comes straight from the request, so the
    // first write lands one cycle after START; afterwards it comes from the counters.
    logic           accept, eng_go;
    logic [X_W-1:0] cx, row_x, end_x;
    logic [Y_W-1:0] cy, end_y;
    logic [C_W-1:0] fill_color;

    always_comb begin
        accept     = (state_q == IDLE) && START;
        cx         = accept ? nx_min : x_q;
        cy         = accept ? ny_min : y_q;
        row_x      = accept ? nx_min : xmin_q;
        end_x      = accept ? nx_max : xmax_q;
        end_y      = accept ? ny_max : ymax_q;
        fill_color = accept ? COLOR  : color_q;
        eng_go     = !CPU_WE && (accept ? !skip : (state_q == FILL && !last_q));
    end

    // NOTE: all state is non-blocking; a later assignment to the same register in
    // this block overrides an earlier one, which is how the pixel advance below
    // takes precedence over the plain latch of the start corner.
    always_ff @(posedge CLK_50MHz or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            last_q  <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (START) begin
                        xmin_q  <= nx_min;
                        xmax_q  <= nx_max;
                        ymax_q  <= ny_max;
                        color_q <= COLOR;
                        x_q     <= nx_min;
                        y_q     <= ny_min;
                        last_q  <= skip;
                        busy_q  <= 1'b1;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // MCU writes win the port; the pixel counters simply hold that cycle.
            if (CPU_WE) begin
                wa_q <= CPU_WA;
                wd_q <= CPU_WD;
                we_q <= 1'b1;
            end else if (eng_go) begin
                wa_q <= {cy, cx};
                wd_q <= fill_color;
                we_q <= 1'b1;
                if (cx == end_x) begin
                    if (cy == end_y) begin
                        last_q <= 1'b1;
                    end else begin
                        x_q <= row_x;
                        y_q <= cy + 7'd1;
                    end
                end else begin
                    x_q <= cx + 8'd1;
                end
            end
        end
    end

    assign WA   = wa_q;
    assign WD   = wd_q;
    assign WE   = we_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: each fill is launched on a falling edge and the
// write bus is logged once per cycle on the following falling edges.
module tb_vga_rect_fill;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_rect_fill_if bus ();

    vga_rect_fill #(.H_RES(160), .V_RES(120)) dut (
        .CLK_50MHz (clk),
        .RST_N     (rst_n),
        .START     (bus.start),
        .X0        (bus.x0),
        .X1        (bus.x1),
        .Y0        (bus.y0),
        .Y1        (bus.y1),
        .COLOR     (bus.color),
        .CPU_WA    (bus.cpu_wa),
        .CPU_WD    (bus.cpu_wd),
        .CPU_WE    (bus.cpu_we),
        .WA        (bus.wa),
        .WD        (bus.wd),
        .WE        (bus.we),
        .BUSY      (bus.busy),
        .DONE      (bus.done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] got_wa[$];
    logic [11:0] got_wd[$];
    logic [14:0] exp_wa[$];
    logic [11:0] exp_wd[$];
    int          done_k, done_cnt, we_cnt;
    logic        busy_k1, busy_after;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [7:0] x0, input logic [7:0] x1,
                           input logic [6:0] y0, input logic [6:0] y1, input logic [11:0] col);
        bus.x0    = x0;
        bus.x1    = x1;
        bus.y0    = y0;
        bus.y1    = y1;
        bus.color = col;
    endtask

    // Called on a falling edge. Cycle k is observed on the k-th falling edge after
    // START is sampled; cpu_k / start2_k schedule an MCU write or a stray START.
    task automatic run_fill(input logic [7:0] x0, input logic [7:0] x1,
                            input logic [6:0] y0, input logic [6:0] y1,
                            input logic [11:0] col, input int cpu_k, input int start2_k);
        got_wa.delete();
        got_wd.delete();
        done_k     = -1;
        done_cnt   = 0;
        busy_k1    = 1'b0;
        busy_after = 1'b1;
        set_req(x0, x1, y0, y1, col);
        bus.start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start  = 1'b0;
            bus.cpu_we = 1'b0;
            if (bus.we) begin
                got_wa.push_back(bus.wa);
                got_wd.push_back(bus.wd);
            end
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == 1) busy_k1 = bus.busy;
            if (done_k > 0 && k == done_k + 1) busy_after = bus.busy;
            if (k == cpu_k) begin
                bus.cpu_we = 1'b1;
                bus.cpu_wa = 15'h1234;
                bus.cpu_wd = 12'h0AB;
            end
            if (k == start2_k) begin
                set_req(8'd50, 8'd60, 7'd50, 7'd60, 12'hFFF);
                bus.start = 1'b1;
            end
            if (done_k > 0 && k >= done_k + 2) break;
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, " write count"}, got_wa.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
            check($sformatf("%s WA[%0d]", tag, i), got_wa[i], exp_wa[i]);
            check($sformatf("%s WD[%0d]", tag, i), got_wd[i], exp_wd[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_ks[$];
        int dcount;

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_wa = '0;
        bus.cpu_wd = '0;
        set_req(8'd0, 8'd0, 7'd0, 7'd0, 12'h000);
        repeat (3) @(negedge clk);
        check("reset WA", bus.wa, 15'h0);
        check("reset WD", bus.wd, 12'h0);
        check("reset WE", bus.we, 1'b0);
        check("reset BUSY", bus.busy, 1'b0);
        check("reset DONE", bus.done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 3x2 fill.
        run_fill(8'd2, 8'd4, 7'd3, 7'd4, 12'hF00, -1, -1);
        exp_wa = '{15'h0302, 15'h0303, 15'h0304, 15'h0402, 15'h0403, 15'h0404};
        exp_wd = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00};
        check_seq("basic");
        check("basic DONE cycle", done_k, 7);
        check("basic DONE pulses", done_cnt, 1);
        check("basic BUSY in fill", busy_k1, 1'b1);
        check("basic BUSY after", busy_after, 1'b0);
        check("idle holds WA", bus.wa, 15'h0404);
        check("idle holds WD", bus.wd, 12'hF00);
        check("idle WE low", bus.we, 1'b0);

        // MCU write during the second pixel slot.
        run_fill(8'd2, 8'd4, 7'd3, 7'd4, 12'hF00, 1, -1);
        exp_wa = '{15'h0302, 15'h1234, 15'h0303, 15'h0304, 15'h0402, 15'h0403, 15'h0404};
        exp_wd = '{12'hF00, 12'h0AB, 12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00};
        check_seq("cpu");
        check("cpu DONE cycle", done_k, 8);

        // Swapped corners.
        run_fill(8'd10, 8'd8, 7'd5, 7'd5, 12'h0F0, -1, -1);
        exp_wa = '{15'h0508, 15'h0509, 15'h050A};
        exp_wd = '{12'h0F0, 12'h0F0, 12'h0F0};
        check_seq("swap");
        check("swap DONE cycle", done_k, 4);

        // Clipping at the right and bottom edges.
        run_fill(8'd158, 8'd200, 7'd118, 7'd127, 12'h00F, -1, -1);
        exp_wa = '{15'h769E, 15'h769F, 15'h779E, 15'h779F};
        exp_wd = '{12'h00F, 12'h00F, 12'h00F, 12'h00F};
        check_seq("clip");
        check("clip DONE cycle", done_k, 5);

        // START pulsed again while busy must not disturb or queue anything.
        run_fill(8'd2, 8'd4, 7'd3, 7'd4, 12'h5A5, -1, 2);
        exp_wa = '{15'h0302, 15'h0303, 15'h0304, 15'h0402, 15'h0403, 15'h0404};
        exp_wd = '{12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5};
        check_seq("busy start");
        check("busy start DONE cycle", done_k, 7);
        check("busy start not queued", bus.we, 1'b0);

        // Off-screen rectangle: no writes, DONE two cycles after START.
        run_fill(8'd200, 8'd210, 7'd5, 7'd5, 12'h777, -1, -1);
        exp_wa.delete();
        exp_wd.delete();
        check_seq("offscreen");
        check("offscreen DONE cycle", done_k, 2);

        // START held high: single-pixel fills restart right after returning to IDLE.
        set_req(8'd2, 8'd2, 7'd3, 7'd3, 12'h111);
        bus.start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.we) we_ks.push_back(k);
        end
        bus.start = 1'b0;
        check("held write count", we_ks.size(), 2);
        if (we_ks.size() == 2) begin
            check("held first write cycle", we_ks[0], 1);
            check("held second write cycle", we_ks[1], 4);
        end
        repeat (4) @(negedge clk);

        // Reset after the third pixel of a 10x10 fill aborts it for good.
        set_req(8'd0, 8'd9, 7'd0, 7'd9, 12'h123);
        bus.start = 1'b1;
        we_cnt    = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.we) we_cnt++;
        end
        check("abort pixels before reset", we_cnt, 3);
        rst_n = 1'b0;
        #1;
        check("abort WE", bus.we, 1'b0);
        check("abort BUSY", bus.busy, 1'b0);
        check("abort WA cleared", bus.wa, 15'h0);
        dcount = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done || bus.we) dcount++;
        end
        check("abort quiet in reset", dcount, 0);
        rst_n = 1'b1;
        run_fill(8'd20, 8'd21, 7'd10, 7'd10, 12'h456, -1, -1);
        exp_wa = '{15'h0A14, 15'h0A15};
        exp_wd = '{12'h456, 12'h456};
        check_seq("restart");
        check("restart DONE cycle", done_k, 3);
        check("restart DONE pulses", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter H_RES, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter V_RES, default 120, framebuffer height in pixels.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as follows.
- CLK_50MHz  in  1  system clock; all logic is on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
REQ-004 SHALL have these remaining ports:
- START  in  1  request a fill; sampled only in IDLE.
- X0, X1  in  8  column corners.
- Y0, Y1  in  7  row corners.
- COLOR  in  12  fill colour as {R[3:0],G[3:0],B[3:0]}.
- CPU_WA  in  15  MCU framebuffer write address.
- CPU_WD  in  12  MCU write data.
- CPU_WE  in  1  MCU write strobe.
- WA  out  15  framebuffer write address.
- WD  out  12  framebuffer write data.
- WE  out  1  framebuffer write enable.
- BUSY  out  1  fill in progress.
- DONE  out  1  one-cycle completion pulse.

Function
REQ-005 SHALL implement FSM states IDLE, FILL and FINISH.
REQ-006 In IDLE, START=1 SHALL latch corners and COLOR and enter FILL on the next edge.
REQ-007 On latch, SHALL normalise corners so that xmin=min(X0,X1), xmax=max(X0,X1), and likewise for y.
REQ-008 On latch, SHALL clip xmax to H_RES-1 and ymax to V_RES-1.
REQ-009 If xmin>H_RES-1 or ymin>V_RES-1, SHALL skip FILL, go directly to FINISH, and issue no engine writes.
REQ-010 SHALL write pixels in row-major order: x from xmin to xmax, then y+1, ending at (xmax,ymax).
REQ-011 SHALL form each address as WA={y[6:0],x[7:0]}, with WD=latched COLOR.
REQ-012 SHALL make WA, WD and WE registered outputs; the first engine WE is asserted the cycle after the START cycle.
REQ-013 SHALL write one pixel per cycle when the MCU is not writing; an uncontended fill takes (xmax-xmin+1)*(ymax-ymin+1) cycles of WE.
REQ-014 SHALL give CPU_WE=1 priority in every state: the next cycle outputs WA=CPU_WA, WD=CPU_WD, WE=1, and the engine's pixel counters hold (no pixel skipped or duplicated).
REQ-015 SHALL pass MCU writes through with exactly one cycle of latency in IDLE, FILL and FINISH alike.
REQ-016 After the final pixel write is registered, SHALL enter FINISH for one cycle, assert DONE=1 for that cycle, then return to IDLE.
REQ-017 SHALL drive BUSY=1 in FILL and FINISH, and 0 in IDLE.
REQ-018 SHALL ignore START while BUSY=1; it is not queued.
REQ-019 With START held high continuously, SHALL begin a new fill the cycle after returning to IDLE.
REQ-020 SHALL make counters exactly as wide as the coordinate ports (8-bit x, 7-bit y) with no wrap-around: the end condition is an equality compare against xmax/ymax.
REQ-021 In IDLE with no MCU write, SHALL drive WE=0 and hold WA and WD at their previous values.

Reset
REQ-022 While RST_N=0, SHALL drive state=IDLE, WA=0, WD=0, WE=0, BUSY=0 and DONE=0, and clear the latched corners and colour.
REQ-023 Reset asserted mid-fill SHALL abort the fill immediately, with no DONE and no resumption after release.
REQ-024 After RST_N deasserts, the first START SHALL be honoured on the first rising edge.

Structure
REQ-025 SHALL place the state enum (IDLE, FILL, FINISH) and the H_RES/V_RES default constants in shared package vga_pkg.
REQ-026 SHALL be a single module with no sub-modules; it instantiates directly upstream of VGA_FB_Driver WA/WD/WE.

Verification
REQ-027 Fill (2,3)-(4,4), COLOR=0xF00, no CPU writes -> six WE pulses at WA 0x0302, 0x0303, 0x0304, 0x0402, 0x0403, 0x0404, then DONE one cycle after the last pulse.
REQ-028 Swapped corners X0=10,X1=8,Y0=5,Y1=5 -> writes at 0x0508, 0x0509, 0x050A only.
REQ-029 Fill (158,118)-(200,127) -> clipped to 4 writes: 0x769E, 0x769F, 0x779E, 0x779F.
REQ-030 CPU_WE=1 (CPU_WA=0x1234, CPU_WD=0x0AB) during the 2nd pixel of REQ-027 -> output sequence 0x0302, 0x1234/0x0AB, 0x0303, ..., with all six fill pixels present.
REQ-031 RST_N=0 after the 3rd pixel of a 100-pixel fill -> WE=0 and BUSY=0 immediately; DONE never pulses; a START after release restarts from the new corners.
REQ-032 START pulsed while BUSY -> ignored; X0=200 -> no writes and DONE two cycles after START.
